// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU op codes, forwarding selects and issue-entry layout.
package fpu_pkg;
    localparam logic [2:0] FC_ADD  = 3'b000;
    localparam logic [2:0] FC_SUB  = 3'b001;
    localparam logic [2:0] FC_MUL  = 3'b010;
    localparam logic [2:0] FC_DIV  = 3'b100;
    localparam logic [2:0] FC_SQRT = 3'b110;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_ED = 2'd1;
    localparam logic [1:0] FWD_WD = 2'd2;

    localparam int FCW = 3;
    localparam int RW  = 5;

    typedef struct packed {
        logic [FCW-1:0] fc;
        logic [RW-1:0]  fd;
        logic [RW-1:0]  fs;
        logic [RW-1:0]  ft;
        logic           useb;
        logic           wf;
    } entry_t;
endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: decoded FP instruction handshake from the integer pipeline.
interface fpu_issue_ctrl_if;
    import fpu_pkg::*;
    logic           in_valid;
    logic           in_ready;
    logic [FCW-1:0] in_fc;
    logic [RW-1:0]  in_fd;
    logic [RW-1:0]  in_fs;
    logic [RW-1:0]  in_ft;
    logic           in_useb;
    logic           in_wf;

    modport master (output in_valid, in_fc, in_fd, in_fs, in_ft, in_useb, in_wf, input in_ready);
    modport slave  (input in_valid, in_fc, in_fd, in_fs, in_ft, in_useb, in_wf, output in_ready);
endinterface

// File: rtl/fpu_fwd_unit.sv
// fpu_fwd_unit: RAW hazard and forwarding select for one source operand.
module fpu_fwd_unit
    import fpu_pkg::*;
(
    input  logic [RW-1:0] src_i,
    input  logic          use_i,
    input  logic [RW-1:0] e1n_i,
    input  logic [RW-1:0] e2n_i,
    input  logic [RW-1:0] e3n_i,
    input  logic [RW-1:0] wn_i,
    input  logic          e1w_i,
    input  logic          e2w_i,
    input  logic          e3w_i,
    input  logic          ww_i,
    output logic          hz_o,
    output logic [1:0]    fwd_o
);
    assign hz_o = use_i & ((e1w_i & (e1n_i == src_i)) | (e2w_i & (e2n_i == src_i)));

    // E3 is the younger result, so it wins over W
    always_comb
        fwd_o = ~use_i                    ? FWD_RF :
                e3w_i & (e3n_i == src_i)  ? FWD_ED :
                ww_i & (wn_i == src_i)    ? FWD_WD : FWD_RF;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: buffers FP instructions, checks RAW hazards against the FPU
// pipe, and issues instructions or bubbles with operand forwarding selects.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clrn,
    fpu_issue_ctrl_if.slave  in_if,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    input  logic [RW-1:0]    e1n_i,
    input  logic [RW-1:0]    e2n_i,
    input  logic [RW-1:0]    e3n_i,
    input  logic [RW-1:0]    wn_i,
    input  logic             e1w_i,
    input  logic             e2w_i,
    input  logic             e3w_i,
    input  logic             ww_i,
    input  logic             st_ds_i,
    output logic [FCW-1:0]   fc_o,
    output logic [RW-1:0]    fd_o,
    output logic             wf_o,
    output logic [RW-1:0]    rs_o,
    output logic [RW-1:0]    rt_o,
    output logic             ein1_o,
    output logic             ein2_o,
    output logic [1:0]       fwda_o,
    output logic [1:0]       fwdb_o,
    output logic [AW:0]      count_o,
    output logic [15:0]      hz_cnt_o
);
    entry_t      mem_q [DEPTH];
    entry_t      head;
    logic [AW:0] wp_q, wp_d, rp_q, rp_d, cnt;
    logic [15:0] hz_cnt_q, hz_cnt_d;
    logic        valid, full, push, adv, issue, hz, hz_a, hz_b;
    logic [1:0]  fa, fb;

    assign cnt   = wp_q - rp_q;
    assign head  = mem_q[rp_q[AW-1:0]];
    assign valid = cnt != '0;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign push  = in_if.in_valid & ~full & ~flush_i;
    assign adv   = ~mem_stall_i & ~st_ds_i;
    assign hz    = valid & (hz_a | hz_b);
    assign issue = valid & ~hz & adv & ~flush_i;

    fpu_fwd_unit u_fwd_a (
        .src_i(head.fs), .use_i(1'b1),
        .e1n_i, .e2n_i, .e3n_i, .wn_i, .e1w_i, .e2w_i, .e3w_i, .ww_i,
        .hz_o(hz_a), .fwd_o(fa)
    );

    fpu_fwd_unit u_fwd_b (
        .src_i(head.ft), .use_i(head.useb),
        .e1n_i, .e2n_i, .e3n_i, .wn_i, .e1w_i, .e2w_i, .e3w_i, .ww_i,
        .hz_o(hz_b), .fwd_o(fb)
    );

    // a flush empties the buffer by catching the read pointer up to the write pointer
    always_comb begin
        wp_d     = wp_q + (AW+1)'(push);
        rp_d     = flush_i ? wp_q : rp_q + (AW+1)'(issue);
        hz_cnt_d = (hz & adv & ~flush_i & ~&hz_cnt_q) ? hz_cnt_q + 16'd1 : hz_cnt_q;
    end

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            wp_q     <= '0;
            rp_q     <= '0;
            hz_cnt_q <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            hz_cnt_q <= hz_cnt_d;
        end

    always_ff @(posedge clk)
        if (push)
            mem_q[wp_q[AW-1:0]] <= '{fc: in_if.in_fc, fd: in_if.in_fd, fs: in_if.in_fs,
                                     ft: in_if.in_ft, useb: in_if.in_useb, wf: in_if.in_wf};

    always_comb begin
        fc_o           = issue ? head.fc : '0;
        fd_o           = issue ? head.fd : '0;
        wf_o           = issue & head.wf;
        rs_o           = valid ? head.fs : '0;
        rt_o           = valid ? head.ft : '0;
        fwda_o         = valid ? fa : FWD_RF;
        fwdb_o         = valid ? fb : FWD_RF;
        ein1_o         = ~clrn | ~mem_stall_i;
        ein2_o         = ~clrn | ~flush_i;
        in_if.in_ready = ~full;
        count_o        = cnt;
        hz_cnt_o       = hz_cnt_q;
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized stimulus against a queue-based reference model,
// expected responses scoreboarded and checked by an independent monitor.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    typedef struct {
        bit         v;
        entry_t     e;
        bit         ms, fl, sd;
        logic [4:0] n1, n2, n3, n4;
        bit         w1, w2, w3, w4;
    } stim_t;

    typedef struct {
        logic [2:0] fc;
        logic [4:0] fd;
        logic       wf;
    } iss_t;

    typedef struct {
        bit         valid, issued, rdy, e1, e2;
        int         cnt, hz;
        logic [4:0] rs, rt;
        logic [1:0] fa, fb;
    } st_t;

    logic clk = 0, clrn = 0;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if bus ();
    logic       ms = 0, fl = 0, sd = 0;
    logic [4:0] e1n = 0, e2n = 0, e3n = 0, wn = 0;
    logic       e1w = 0, e2w = 0, e3w = 0, ww = 0;
    logic [2:0] fc_o;
    logic [4:0] fd_o, rs_o, rt_o;
    logic       wf_o, ein1_o, ein2_o;
    logic [1:0] fwda_o, fwdb_o;
    logic [2:0] count_o;
    logic [15:0] hz_cnt_o;

    fpu_issue_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .clrn(clrn), .in_if(bus),
        .mem_stall_i(ms), .flush_i(fl),
        .e1n_i(e1n), .e2n_i(e2n), .e3n_i(e3n), .wn_i(wn),
        .e1w_i(e1w), .e2w_i(e2w), .e3w_i(e3w), .ww_i(ww),
        .st_ds_i(sd),
        .fc_o(fc_o), .fd_o(fd_o), .wf_o(wf_o), .rs_o(rs_o), .rt_o(rt_o),
        .ein1_o(ein1_o), .ein2_o(ein2_o), .fwda_o(fwda_o), .fwdb_o(fwdb_o),
        .count_o(count_o), .hz_cnt_o(hz_cnt_o)
    );

    entry_t mq[$];
    int     mhz = 0;
    iss_t   iq[$];
    st_t    sq[$];
    int     vec = 0, errs = 0;

    task automatic chk(string nm, int act, int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(logic [4:0] s, bit u);
        if (!u) return 2'd0;
        if (e3w && e3n == s) return 2'd1;
        if (ww && wn == s) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit busy(logic [4:0] s);
        return (e1w && e1n == s) || (e2w && e2n == s);
    endfunction

    task automatic step(input stim_t t);
        entry_t h;
        st_t    s;
        bit     valid, hz, adv, iss, pu;
        @(posedge clk);
        #1;
        bus.in_valid = t.v; bus.in_fc = t.e.fc; bus.in_fd = t.e.fd; bus.in_fs = t.e.fs;
        bus.in_ft = t.e.ft; bus.in_useb = t.e.useb; bus.in_wf = t.e.wf;
        ms = t.ms; fl = t.fl; sd = t.sd;
        e1n = t.n1; e2n = t.n2; e3n = t.n3; wn = t.n4;
        e1w = t.w1; e2w = t.w2; e3w = t.w3; ww = t.w4;
        #1;
        valid = mq.size() > 0;
        h     = valid ? mq[0] : '0;
        hz    = valid && (busy(h.fs) || (h.useb && busy(h.ft)));
        adv   = !t.ms && !t.sd;
        iss   = valid && !hz && adv && !t.fl;
        s.valid = valid; s.issued = iss; s.rdy = mq.size() < 4;
        s.e1 = !t.ms; s.e2 = !t.fl; s.cnt = mq.size(); s.hz = mhz;
        s.rs = h.fs; s.rt = h.ft; s.fa = ref_fwd(h.fs, 1'b1); s.fb = ref_fwd(h.ft, h.useb);
        sq.push_back(s);
        if (iss) iq.push_back('{fc: h.fc, fd: h.fd, wf: h.wf});
        pu = t.v && mq.size() < 4 && !t.fl;
        if (hz && adv && !t.fl && mhz < 65535) mhz++;
        if (t.fl) mq.delete();
        else begin
            if (iss) void'(mq.pop_front());
            if (pu) mq.push_back(t.e);
        end
    endtask

    function automatic stim_t rand_stim(int p_ms, int p_sd, int p_fl);
        stim_t t;
        t.v = $urandom_range(99) < 60;
        t.e.fc = 3'($urandom); t.e.fd = 5'($urandom_range(1, 7));
        t.e.fs = 5'($urandom_range(1, 7)); t.e.ft = 5'($urandom_range(1, 7));
        t.e.useb = $urandom_range(99) < 80; t.e.wf = 1'($urandom);
        t.ms = $urandom_range(99) < p_ms; t.sd = $urandom_range(99) < p_sd;
        t.fl = $urandom_range(99) < p_fl;
        t.n1 = 5'($urandom_range(1, 7)); t.n2 = 5'($urandom_range(1, 7));
        t.n3 = 5'($urandom_range(1, 7)); t.n4 = 5'($urandom_range(1, 7));
        t.w1 = $urandom_range(99) < 30; t.w2 = $urandom_range(99) < 30;
        t.w3 = $urandom_range(99) < 50; t.w4 = $urandom_range(99) < 50;
        return t;
    endfunction

    function automatic stim_t idle_stim(bit v, logic [4:0] fd, bit ms_, bit fl_);
        stim_t t = '{default: 0};
        t.v = v; t.e.fc = FC_ADD; t.e.fd = fd; t.e.fs = 5'd1; t.e.ft = 5'd2;
        t.e.useb = 1'b1; t.e.wf = 1'b1; t.ms = ms_; t.fl = fl_;
        return t;
    endfunction

    task automatic reset_check();
        chk("rst_count", count_o, 0);
        chk("rst_hz_cnt", hz_cnt_o, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_fc_fd_wf", {fc_o, fd_o, wf_o}, 0);
        chk("rst_rs_rt", {rs_o, rt_o}, 0);
        chk("rst_fwd", {fwda_o, fwdb_o}, 0);
        chk("rst_ein", {ein1_o, ein2_o}, 2'b11);
    endtask

    always @(negedge clk) begin
        st_t  s;
        iss_t x;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("count", count_o, s.cnt);
            chk("hz_cnt", hz_cnt_o, s.hz);
            chk("in_ready", bus.in_ready, s.rdy);
            chk("ein1", ein1_o, s.e1);
            chk("ein2", ein2_o, s.e2);
            if (s.valid) begin
                chk("rs", rs_o, s.rs);
                chk("rt", rt_o, s.rt);
                chk("fwda", fwda_o, s.fa);
                chk("fwdb", fwdb_o, s.fb);
            end
            chk("issued", fd_o != 0, s.issued);
            if (s.issued) begin
                x = iq.pop_front();
                chk("iss_fc", fc_o, x.fc);
                chk("iss_fd", fd_o, x.fd);
                chk("iss_wf", wf_o, x.wf);
            end else
                chk("bubble_fc_wf", {fc_o, wf_o}, 0);
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_fc = 0; bus.in_fd = 0; bus.in_fs = 0;
        bus.in_ft = 0; bus.in_useb = 0; bus.in_wf = 0;
        ms = 1; fl = 1;
        #2 reset_check();
        @(posedge clk); #1 clrn = 1; ms = 0; fl = 0;
        // fill to full under mem_stall, then drain one per cycle
        for (int i = 1; i <= 5; i++) step(idle_stim(1'b1, 5'(i), 1'b1, 1'b0));
        for (int i = 0; i < 5; i++) step(idle_stim(1'b0, 5'd0, 1'b0, 1'b0));
        // flush with three buffered and a push in the same cycle
        for (int i = 1; i <= 3; i++) step(idle_stim(1'b1, 5'(i + 8), 1'b1, 1'b0));
        step(idle_stim(1'b1, 5'd20, 1'b0, 1'b1));
        step(idle_stim(1'b0, 5'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3000; i++) step(rand_stim(20, 15, 4));
        // reset while busy: outputs return to reset values at once
        for (int i = 0; i < 4; i++) step(idle_stim(1'b1, 5'(i + 1), 1'b1, 1'b0));
        @(posedge clk); #1;
        clrn = 0; ms = 1; fl = 1;
        #1 reset_check();
        mq.delete(); mhz = 0;
        @(posedge clk); #1 clrn = 1;
        for (int i = 0; i < 1500; i++) step(rand_stim(10, 5, 2));
        @(posedge clk); @(negedge clk); #1;
        chk("sb_drained", sq.size() + iq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
